// File: rtl/dcmac_lockstep_packetizer.sv
// Lockstep multi-segment packet FIFO: beats become visible on the output only once their packet
// has been committed with a consistent tlast; oversize and tlast-mismatched packets are dropped.
module dcmac_lockstep_packetizer #(
  parameter int unsigned NSEG            = 4,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned USER_WIDTH      = 5,
  parameter int unsigned MAX_PACKET_SIZE = 16384,
  localparam int unsigned MAX_BEATS = MAX_PACKET_SIZE / (NSEG * DATA_WIDTH / 8),
  localparam int unsigned DEPTH     = 2 * MAX_BEATS,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned LW        = AW + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NSEG*DATA_WIDTH-1:0] in_tdata,
  input  logic [NSEG*USER_WIDTH-1:0] in_tuser,
  input  logic [NSEG-1:0]            in_tlast,
  input  logic [NSEG-1:0]            in_tvalid,
  output logic [NSEG-1:0]            in_tready,
  output logic [NSEG*DATA_WIDTH-1:0] out_tdata,
  output logic [NSEG*USER_WIDTH-1:0] out_tuser,
  output logic [NSEG-1:0]            out_tlast,
  output logic [NSEG-1:0]            out_tvalid,
  input  logic [NSEG-1:0]            out_tready,
  output logic [31:0]                pkt_count,
  output logic [15:0]                drop_oversize_count,
  output logic [15:0]                drop_mismatch_count,
  output logic [LW-1:0]              fifo_level
);

  localparam int unsigned EW = NSEG * DATA_WIDTH + NSEG * USER_WIDTH + 1;

  typedef enum logic [0:0] {StWrite, StDiscard} wr_state_e;

  wr_state_e     state_q, state_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] pkt_start_q, pkt_start_d, beat_cnt_q, beat_cnt_d;
  logic [31:0]   pkt_count_q, pkt_count_d;
  logic [15:0]   drop_oversize_q, drop_oversize_d, drop_mismatch_q, drop_mismatch_d;
  logic [EW-1:0] out_entry_q, out_entry_d;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] mem [DEPTH];

  logic          eop, tlast_match, in_ready, wr_en, out_fire;
  logic [LW-1:0] level, committed;

  // Pointers carry one extra wrap bit so full (DEPTH) and empty (0) are distinct.
  assign level       = wr_ptr_q - rd_ptr_q;
  assign committed   = pkt_start_q - rd_ptr_q;
  assign eop         = |in_tlast;
  assign tlast_match = &in_tlast;
  assign in_ready    = ~reset & (&in_tvalid) & ((state_q == StDiscard) | (level < LW'(DEPTH)));
  assign wr_en       = in_ready & (state_q == StWrite);
  assign out_fire    = out_valid_q & (&out_tready);

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    pkt_start_d     = pkt_start_q;
    beat_cnt_d      = beat_cnt_q;
    drop_oversize_d = drop_oversize_q;
    drop_mismatch_d = drop_mismatch_q;
    if (in_ready) begin
      unique case (state_q)
        StWrite: begin
          if (eop) begin
            beat_cnt_d = '0;
            if (tlast_match) begin
              wr_ptr_d    = wr_ptr_q + LW'(1);
              pkt_start_d = wr_ptr_q + LW'(1);
            end else begin
              wr_ptr_d = pkt_start_q;
              if (~&drop_mismatch_q) drop_mismatch_d = drop_mismatch_q + 16'd1;
            end
          end else if (beat_cnt_q == LW'(MAX_BEATS - 1)) begin
            // Non-EOP at the size limit: the packet can never fit, so throw away its tail too.
            wr_ptr_d   = pkt_start_q;
            beat_cnt_d = '0;
            state_d    = StDiscard;
            if (~&drop_oversize_q) drop_oversize_d = drop_oversize_q + 16'd1;
          end else begin
            wr_ptr_d   = wr_ptr_q + LW'(1);
            beat_cnt_d = beat_cnt_q + LW'(1);
          end
        end
        StDiscard: begin
          if (eop) state_d = StWrite;
        end
        default: state_d = StWrite;
      endcase
    end
  end

  // Output register mirrors mem[rd_ptr]; the entry is only released on a completed transfer.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    pkt_count_d = pkt_count_q;
    if (out_fire) begin
      rd_ptr_d = rd_ptr_q + LW'(1);
      if (out_entry_q[EW-1] && ~&pkt_count_q) pkt_count_d = pkt_count_q + 32'd1;
      if (committed > LW'(1)) out_entry_d = mem[rd_ptr_d[AW-1:0]];
      else                    out_valid_d = 1'b0;
    end else if (!out_valid_q && committed != '0) begin
      out_entry_d = mem[rd_ptr_q[AW-1:0]];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StWrite;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      pkt_start_q     <= '0;
      beat_cnt_q      <= '0;
      pkt_count_q     <= '0;
      drop_oversize_q <= '0;
      drop_mismatch_q <= '0;
      out_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      pkt_start_q     <= pkt_start_d;
      beat_cnt_q      <= beat_cnt_d;
      pkt_count_q     <= pkt_count_d;
      drop_oversize_q <= drop_oversize_d;
      drop_mismatch_q <= drop_mismatch_d;
      out_valid_q     <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    out_entry_q <= out_entry_d;
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {eop, in_tuser, in_tdata};
  end

  assign in_tready           = {NSEG{in_ready}};
  assign out_tvalid          = {NSEG{out_valid_q}};
  assign out_tlast           = {NSEG{out_entry_q[EW-1]}};
  assign out_tuser           = out_entry_q[NSEG*DATA_WIDTH +: NSEG*USER_WIDTH];
  assign out_tdata           = out_entry_q[NSEG*DATA_WIDTH-1:0];
  assign pkt_count           = pkt_count_q;
  assign drop_oversize_count = drop_oversize_q;
  assign drop_mismatch_count = drop_mismatch_q;
  assign fifo_level          = level;

endmodule

// File: doc/dcmac_lockstep_packetizer.md
DCMAC_LOCKSTEP_PACKETIZER -- requirements
Module: dcmac_lockstep_packetizer

Interface
REQ-001 SHALL have parameter NSEG, default 4: number of lockstep segments (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 128: tdata bits per segment (multiple of 8).
REQ-003 SHALL have parameter USER_WIDTH, default 5: tuser bits per segment.
REQ-004 SHALL have parameter MAX_PACKET_SIZE, default 16384: largest legal packet in bytes; MAX_BEATS = MAX_PACKET_SIZE/(NSEG*DATA_WIDTH/8), a power of two (256 at defaults).
REQ-005 SHALL derive DEPTH = 2*MAX_BEATS entries and LW = log2(DEPTH)+1.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 in_tdata  in  NSEG*DATA_WIDTH  segment s at bits [s*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_tuser  in  NSEG*USER_WIDTH  per-segment tuser, same packing.
REQ-011 in_tlast / in_tvalid  in  NSEG each  per-segment tlast / tvalid.
REQ-012 in_tready  out  NSEG  per-segment ready, all bits always equal.
REQ-013 out_tdata / out_tuser  out  NSEG*DATA_WIDTH / NSEG*USER_WIDTH  stored beat.
REQ-014 out_tlast / out_tvalid  out  NSEG each  all bits of each vector always equal.
REQ-015 out_tready  in  NSEG  per-segment ready.
REQ-016 pkt_count  out  32  packets fully delivered on output, saturating.
REQ-017 drop_oversize_count / drop_mismatch_count  out  16 each  dropped packets, saturating.
REQ-018 fifo_level  out  LW  occupied entries, committed plus uncommitted.

Function
REQ-019 SHALL store all NSEG segments of a beat in one shared entry so segments enter and exit in lockstep.
REQ-020 SHALL accept an input beat only when all in_tvalid bits are 1 and in_tready is 1; in_tready may depend on in_tvalid.
REQ-021 SHALL treat an accepted beat as end-of-packet (EOP) when any in_tlast bit is 1.
REQ-022 SHALL run write FSM states WRITE (reset state) and DISCARD.
REQ-023 WRITE: in_tready = &in_tvalid & (fifo_level < DEPTH); each accepted beat is written at wr_ptr, wr_ptr increments, beat counter increments.
REQ-024 WRITE, EOP with all in_tlast equal: SHALL commit the packet (pkt_start <= wr_ptr+1; beats become readable); beat counter clears.
REQ-025 WRITE, EOP with in_tlast not all equal: SHALL rewind wr_ptr to pkt_start, increment drop_mismatch_count, clear beat counter; state stays WRITE.
REQ-026 WRITE, accepted non-EOP beat that is beat number MAX_BEATS of its packet: SHALL rewind wr_ptr to pkt_start, increment drop_oversize_count, go to DISCARD.
REQ-027 A packet of exactly MAX_BEATS beats whose last beat is EOP SHALL be committed, not dropped.
REQ-028 DISCARD: in_tready = &in_tvalid; beats are accepted and not written; on EOP, whether or not tlast bits match, SHALL go to WRITE; no additional count.
REQ-029 Output SHALL present only committed beats, in order; out_tvalid deasserts once no committed beat remains, even if uncommitted beats are stored.
REQ-030 SHALL complete an output transfer when out_tvalid=1 and &out_tready=1; pkt_count increments when that beat has out_tlast=1.
REQ-031 Latency: with FIFO and output empty, an EOP beat accepted in cycle T SHALL give out_tvalid=1 with the first beat in cycle T+2.
REQ-032 SHALL sustain one beat per cycle in and out, including simultaneous write, commit, rewind and read in one cycle.
REQ-033 out_tdata/out_tuser/out_tlast SHALL stay stable while out_tvalid=1 and &out_tready=0.
REQ-034 Pointers SHALL wrap modulo DEPTH; full when fifo_level = DEPTH, empty when 0.
REQ-035 Counters SHALL saturate at all-ones and not wrap.

Reset
REQ-036 On reset, the next clock edge SHALL clear pointers, pkt_start, the beat counter, all counters and fifo_level to 0, set state to WRITE, and drive in_tready=0 and out_tvalid=0.
REQ-037 Reset mid-packet SHALL discard all stored and partial data; the first beat accepted after reset starts a new packet.

Verification
REQ-038 Defaults, 4-beat packet with all tlast=1 on beat 4 in cycle T -> out_tvalid=1 at T+2, 4 beats out in order, pkt_count=1.
REQ-039 3-beat packet with in_tlast=4'b0011 on beat 3 -> no output, drop_mismatch_count=1, fifo_level=0; next good packet delivered intact.
REQ-040 300-beat packet -> drop_oversize_count=1, beats 257..300 accepted and dropped, fifo_level=0; next 256-beat packet delivered.
REQ-041 out_tready=4'b0111 held, two 256-beat packets sent -> in_tready=0 at fifo_level=512; releasing out_tready drains 512 beats, pkt_count=2.
REQ-042 Reset asserted on beat 2 of 5 -> fifo_level=0, out_tvalid=0; a following 2-beat packet is delivered as exactly 2 beats.
REQ-043 in_tvalid=4'b1110 held for 10 cycles -> in_tready=0, nothing written, fifo_level=0.
